// File: rtl/modulo_updown_counter_pkg.sv
// Shared encodings and defaults for the modulo up/down counter family.
// Optional prescaler is enabled by defining MODULO_COUNTER_PRESCALER_EN.
package modulo_updown_counter_pkg;

  localparam int DEFAULT_SIZE     = 16;
  localparam int DEFAULT_PRESCALE = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // A 1-bit register is kept even for PRESCALE == 1 so the prescaler never has zero width.
  function automatic int ps_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/modulo_counter_next.sv
// Combinational next-count and boundary-event logic for the modulo up/down counter.
module modulo_counter_next
  import modulo_updown_counter_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic [SIZE-1:0] q,
  input  logic [SIZE-1:0] limit,
  input  logic            up,
  input  logic            saturate,
  output logic [SIZE-1:0] q_next,
  output logic            boundary
);

  // Value taken when a step crosses the range edge: saturate pins to the edge being hit,
  // wrap jumps to the opposite edge.
  function automatic logic [SIZE-1:0] edge_value(
    input logic [SIZE-1:0] lim,
    input dir_e            dir,
    input mode_e           mode
  );
    logic [SIZE-1:0] v;
    if (dir == DIR_UP) v = (mode == MODE_SAT) ? lim : '0;
    else               v = (mode == MODE_SAT) ? '0  : lim;
    return v;
  endfunction

  dir_e  dir;
  mode_e mode;

  assign dir  = dir_e'(up);
  assign mode = mode_e'(saturate);

  always_comb begin
    q_next   = q;
    boundary = 1'b0;
    if (dir == DIR_UP) begin
      if (q < limit) begin
        q_next = q + 1'b1;
      end else begin
        // Covers q == limit and q above a limit that was lowered mid-count.
        boundary = 1'b1;
        q_next   = edge_value(limit, dir, mode);
      end
    end else begin
      if (q > limit) begin
        q_next = limit;
      end else if (q != '0) begin
        q_next = q - 1'b1;
      end else begin
        boundary = 1'b1;
        q_next   = edge_value(limit, dir, mode);
      end
    end
  end

endmodule

// File: rtl/modulo_updown_counter.sv
// Modulo up/down counter with wrap/saturate, load, terminal-count pulse and sticky overflow.
// Define MODULO_COUNTER_PRESCALER_EN to step only once every PRESCALE Enable pulses.
module modulo_updown_counter
  import modulo_updown_counter_pkg::*;
#(
  parameter int SIZE        = DEFAULT_SIZE,
  parameter int RESET_VALUE = 0,
  parameter int PRESCALE    = DEFAULT_PRESCALE
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Load,
  input  logic [SIZE-1:0] Initial,
  input  logic [SIZE-1:0] Limit,
  input  logic            Enable,
  input  logic            Up,
  input  logic            Saturate,
  input  logic            ClearFlag,
  output logic [SIZE-1:0] Q,
  output logic            TerminalCount,
  output logic            Overflow
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be >= 1");
  end

  function automatic logic [SIZE-1:0] clamp_to_limit(
    input logic [SIZE-1:0] value,
    input logic [SIZE-1:0] lim
  );
    return (value > lim) ? lim : value;
  endfunction

  logic [SIZE-1:0] q_p0;
  logic            tc_p0;
  logic            ovf_p0;
  logic [SIZE-1:0] q_next;
  logic            boundary;
  logic            step;

  modulo_counter_next #(
    .SIZE (SIZE)
  ) u_next (
    .q        (q_p0),
    .limit    (Limit),
    .up       (Up),
    .saturate (Saturate),
    .q_next   (q_next),
    .boundary (boundary)
  );

`ifdef MODULO_COUNTER_PRESCALER_EN
  localparam int              PS_W    = ps_width(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_p0;

  // Prescaler: counts Enable pulses, frozen on idle cycles, restarted by Load.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ps_p0 <= '0;
    end else if (Load) begin
      ps_p0 <= '0;
    end else if (Enable) begin
      ps_p0 <= (ps_p0 == PS_LAST) ? '0 : ps_p0 + 1'b1;
    end
  end

  assign step = Enable && (ps_p0 == PS_LAST);
`else
  assign step = Enable;
`endif

  // Count, terminal-count and overflow registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      q_p0   <= SIZE'(RESET_VALUE);
      tc_p0  <= 1'b0;
      ovf_p0 <= 1'b0;
    end else if (Load) begin
      q_p0   <= clamp_to_limit(Initial, Limit);
      tc_p0  <= 1'b0;
      ovf_p0 <= 1'b0;
    end else begin
      tc_p0 <= step && boundary;
      if (step) begin
        q_p0 <= q_next;
      end
      if (step && boundary) begin
        ovf_p0 <= 1'b1;
      end else if (ClearFlag) begin
        ovf_p0 <= 1'b0;
      end
    end
  end

  assign Q             = q_p0;
  assign TerminalCount = tc_p0;
  assign Overflow      = ovf_p0;

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Scoreboard bench for modulo_updown_counter (SIZE=8, RESET_VALUE=5, PRESCALE=4).
module tb_modulo_updown_counter;

  localparam int SIZE = 8;
  localparam int RV   = 5;
  localparam int PS   = 4;
`ifdef MODULO_COUNTER_PRESCALER_EN
  localparam int STEP_PULSES = PS;
`else
  localparam int STEP_PULSES = 1;
`endif

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic            Load = 1'b0;
  logic [SIZE-1:0] Initial = '0;
  logic [SIZE-1:0] Limit = '0;
  logic            Enable = 1'b0;
  logic            Up = 1'b0;
  logic            Saturate = 1'b0;
  logic            ClearFlag = 1'b0;
  logic [SIZE-1:0] Q;
  logic            TerminalCount;
  logic            Overflow;

  modulo_updown_counter #(
    .SIZE        (SIZE),
    .RESET_VALUE (RV),
    .PRESCALE    (PS)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Load          (Load),
    .Initial       (Initial),
    .Limit         (Limit),
    .Enable        (Enable),
    .Up            (Up),
    .Saturate      (Saturate),
    .ClearFlag     (ClearFlag),
    .Q             (Q),
    .TerminalCount (TerminalCount),
    .Overflow      (Overflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [SIZE-1:0] q;
    logic            tc;
    logic            ovf;
  } exp_t;

  typedef struct {
    logic            load;
    logic [SIZE-1:0] init;
    logic [SIZE-1:0] lim;
    logic            en;
    logic            up;
    logic            sat;
    logic            clr;
    exp_t            e;
  } row_t;

  exp_t sb[$];
  row_t plan[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic add(input logic load, input logic [SIZE-1:0] init, input logic [SIZE-1:0] lim,
                     input logic en, input logic up, input logic sat, input logic clr,
                     input logic [SIZE-1:0] eq, input logic etc, input logic eovf);
    row_t r;
    r.load = load; r.init = init; r.lim = lim; r.en = en; r.up = up; r.sat = sat; r.clr = clr;
    r.e.q = eq; r.e.tc = etc; r.e.ovf = eovf;
    plan.push_back(r);
  endtask

  task automatic drive(input row_t r);
    Load = r.load; Initial = r.init; Limit = r.lim; Enable = r.en;
    Up = r.up; Saturate = r.sat; ClearFlag = r.clr;
    sb.push_back(r.e);
  endtask

  task automatic test_reset();
    exp_t e;
    int   i;
    Limit = 8'd7;
    #1 Reset = 1'b1;
    sb.push_back('{q: 8'(RV), tc: 1'b0, ovf: 1'b0});
    tick(); tick();
    e = sb.pop_front();
    n_checks++;
    if (Q !== e.q || TerminalCount !== e.tc || Overflow !== e.ovf) begin
      n_fail++;
      $display("FAIL reset_state: got Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
               Q, TerminalCount, Overflow, e.q, e.tc, e.ovf);
    end
    Reset = 1'b0;
    add(1, 8'd2, 8'd7, 0, 1, 0, 0, 8'd2, 0, 0);
    for (int k = 1; k <= STEP_PULSES; k++)
      add(0, 8'd0, 8'd7, 1, 1, 0, 0, (k == STEP_PULSES) ? 8'd3 : 8'd2, 0, 0);
    i = 0;
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      tick();
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || TerminalCount !== e.tc || Overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL pre_reset_count[%0d]: got Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
                 i, Q, TerminalCount, Overflow, e.q, e.tc, e.ovf);
      end
      i++;
    end
    // Enable stays high; reset asserted between edges must take effect immediately.
    Reset = 1'b1;
    sb.push_back('{q: 8'(RV), tc: 1'b0, ovf: 1'b0});
    #1;
    e = sb.pop_front();
    n_checks++;
    if (Q !== e.q || TerminalCount !== e.tc || Overflow !== e.ovf) begin
      n_fail++;
      $display("FAIL async_reset: got Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
               Q, TerminalCount, Overflow, e.q, e.tc, e.ovf);
    end
    #1 Reset = 1'b0;
    for (int k = 1; k <= STEP_PULSES; k++)
      add(0, 8'd0, 8'd7, 1, 1, 0, 0, (k == STEP_PULSES) ? 8'd6 : 8'(RV), 0, 0);
    i = 0;
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      tick();
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || TerminalCount !== e.tc || Overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL first_step_after_reset[%0d]: got Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
                 i, Q, TerminalCount, Overflow, e.q, e.tc, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_wrap_up();
    exp_t e;
    int   i;
    add(1, 8'd0, 8'd3, 0, 1, 0, 0, 8'd0, 0, 0);
    add(0, 8'd0, 8'd3, 1, 1, 0, 0, 8'd1, 0, 0);
    add(0, 8'd0, 8'd3, 1, 1, 0, 0, 8'd2, 0, 0);
    add(0, 8'd0, 8'd3, 1, 1, 0, 0, 8'd3, 0, 0);
    add(0, 8'd0, 8'd3, 1, 1, 0, 0, 8'd0, 1, 1);
    add(0, 8'd0, 8'd3, 1, 1, 0, 0, 8'd1, 0, 1);
    add(0, 8'd0, 8'd3, 1, 1, 0, 0, 8'd2, 0, 1);
    i = 0;
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      tick();
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || TerminalCount !== e.tc || Overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: got Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
                 i, Q, TerminalCount, Overflow, e.q, e.tc, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_sat_down();
    exp_t e;
    int   i;
    add(1, 8'd1, 8'd3, 0, 0, 1, 0, 8'd1, 0, 0);
    add(0, 8'd0, 8'd3, 1, 0, 1, 0, 8'd0, 0, 0);
    add(0, 8'd0, 8'd3, 1, 0, 1, 0, 8'd0, 1, 1);
    add(0, 8'd0, 8'd3, 1, 0, 1, 0, 8'd0, 1, 1);
    add(0, 8'd0, 8'd3, 1, 0, 1, 0, 8'd0, 1, 1);
    add(0, 8'd0, 8'd3, 0, 0, 1, 1, 8'd0, 0, 0);
    i = 0;
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      tick();
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || TerminalCount !== e.tc || Overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL sat_down[%0d]: got Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
                 i, Q, TerminalCount, Overflow, e.q, e.tc, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_load_clamp();
    exp_t e;
    int   i;
    add(1, 8'd0, 8'd3, 0, 1, 0, 0, 8'd0, 0, 0);
    add(0, 8'd0, 8'd3, 1, 0, 1, 0, 8'd0, 1, 1);
    add(1, 8'd9, 8'd6, 1, 1, 0, 0, 8'd6, 0, 0);
    add(0, 8'd0, 8'd2, 1, 1, 1, 0, 8'd2, 1, 1);
    add(1, 8'd5, 8'd6, 0, 1, 0, 0, 8'd5, 0, 0);
    add(0, 8'd0, 8'd2, 1, 1, 0, 0, 8'd0, 1, 1);
    add(1, 8'd5, 8'd6, 0, 1, 0, 0, 8'd5, 0, 0);
    add(0, 8'd0, 8'd2, 1, 0, 0, 0, 8'd2, 0, 0);
    add(1, 8'd6, 8'd6, 0, 1, 1, 0, 8'd6, 0, 0);
    add(0, 8'd0, 8'd6, 1, 1, 1, 0, 8'd6, 1, 1);
    i = 0;
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      tick();
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || TerminalCount !== e.tc || Overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL load_clamp[%0d]: got Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
                 i, Q, TerminalCount, Overflow, e.q, e.tc, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_limit_zero();
    exp_t e;
    int   i;
    add(1, 8'd4, 8'd0, 0, 1, 0, 0, 8'd0, 0, 0);
    add(0, 8'd0, 8'd0, 1, 1, 0, 0, 8'd0, 1, 1);
    add(0, 8'd0, 8'd0, 1, 1, 0, 0, 8'd0, 1, 1);
    add(0, 8'd0, 8'd0, 1, 1, 1, 0, 8'd0, 1, 1);
    add(0, 8'd0, 8'd0, 1, 0, 0, 1, 8'd0, 1, 1);
    add(0, 8'd0, 8'd0, 1, 0, 0, 1, 8'd0, 1, 1);
    add(0, 8'd0, 8'd0, 0, 0, 0, 1, 8'd0, 0, 0);
    add(0, 8'd0, 8'hxx, 0, 1'bx, 1'bx, 0, 8'd0, 0, 0);
    i = 0;
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      tick();
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || TerminalCount !== e.tc || Overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL limit_zero[%0d]: got Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
                 i, Q, TerminalCount, Overflow, e.q, e.tc, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   i;
    add(1, 8'd2, 8'd5, 0, 1, 0, 0, 8'd2, 0, 0);
    add(0, 8'd0, 8'd5, 0, 1, 0, 0, 8'd2, 0, 0);
    add(0, 8'd0, 8'd5, 0, 0, 0, 0, 8'd2, 0, 0);
    add(0, 8'd0, 8'd5, 1, 1, 0, 0, 8'd3, 0, 0);
    add(0, 8'd0, 8'd5, 1, 0, 0, 0, 8'd2, 0, 0);
    add(0, 8'd0, 8'd5, 1, 1, 0, 0, 8'd3, 0, 0);
    add(0, 8'd0, 8'd5, 1, 1, 0, 0, 8'd4, 0, 0);
    add(0, 8'd0, 8'd5, 1, 1, 0, 0, 8'd5, 0, 0);
    add(0, 8'd0, 8'd5, 1, 1, 0, 0, 8'd0, 1, 1);
    add(0, 8'd0, 8'd5, 1, 0, 0, 0, 8'd5, 1, 1);
    add(0, 8'd0, 8'd5, 0, 0, 0, 0, 8'd5, 0, 1);
    i = 0;
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      tick();
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || TerminalCount !== e.tc || Overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
                 i, Q, TerminalCount, Overflow, e.q, e.tc, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_prescaler();
    exp_t e;
    int   i;
    add(1, 8'd0, 8'd15, 0, 1, 0, 0, 8'd0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      add(0, 8'd0, 8'd15, 1, 1, 0, 0, 8'(k / 4), 0, 0);
      add(0, 8'd0, 8'd15, 0, 1, 0, 0, 8'(k / 4), 0, 0);
    end
    add(1, 8'd0, 8'd15, 0, 1, 0, 0, 8'd0, 0, 0);
    add(0, 8'd0, 8'd15, 1, 1, 0, 0, 8'd0, 0, 0);
    add(0, 8'd0, 8'd15, 1, 1, 0, 0, 8'd0, 0, 0);
    add(1, 8'd0, 8'd15, 1, 1, 0, 0, 8'd0, 0, 0);
    add(0, 8'd0, 8'd15, 1, 1, 0, 0, 8'd0, 0, 0);
    add(0, 8'd0, 8'd15, 1, 1, 0, 0, 8'd0, 0, 0);
    add(0, 8'd0, 8'd15, 1, 1, 0, 0, 8'd0, 0, 0);
    add(0, 8'd0, 8'd15, 1, 1, 0, 0, 8'd1, 0, 0);
    i = 0;
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      tick();
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || TerminalCount !== e.tc || Overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL prescaler[%0d]: got Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
                 i, Q, TerminalCount, Overflow, e.q, e.tc, e.ovf);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
`ifdef MODULO_COUNTER_PRESCALER_EN
    test_prescaler();
`else
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_limit_zero();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/modulo_updown_counter.md
Name: modulo_updown_counter

Overview:
Parametrised successor to the fixed-width collateral up-counters (16/32/3-bit).
- Adds runtime modulus, up/down direction, wrap-or-saturate mode, synchronous load, a terminal-count pulse and a sticky overflow flag.
- Used by sequencers and address generators in the ray-cast core wherever a bounded index is walked in either direction.

Parameters:
- SIZE, 16, counter width in bits.
- RESET_VALUE, 0, value of Q after asynchronous reset.
- PRESCALE, 4, Enable pulses per counter step; used only with the optional feature, must be >= 1.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Load  input  1  synchronous load of Initial; highest synchronous priority.
- Initial  input  SIZE  load value.
- Limit  input  SIZE  inclusive upper bound; count range is 0..Limit.
- Enable  input  1  request one step this cycle.
- Up  input  1  1 = increment, 0 = decrement.
- Saturate  input  1  1 = hold at boundary, 0 = wrap.
- ClearFlag  input  1  synchronous clear of Overflow.
- Q  output  SIZE  registered count.
- TerminalCount  output  1  registered one-cycle pulse on a boundary event.
- Overflow  output  1  sticky boundary-event flag.

Behaviour:
- Reset: Clock is rising-edge; Reset is asynchronous, active-high. While Reset is high: Q = RESET_VALUE, TerminalCount = 0, Overflow = 0. Prescaler is cleared under the feature. Reset mid-count aborts immediately; first step is taken on the first enabled edge after deassertion.
- Synchronous priority: Load > step > hold.
- Load:
  - Q <= min(Initial, Limit).
  - TerminalCount <= 0, Overflow <= 0.
  - Prescaler cleared.
  - Enable in the same cycle is ignored.
- Step: a step is an Enable cycle; under the feature, only qualified prescaler cycles.
- Up step:
  - Q < Limit: Q <= Q+1.
  - Q == Limit: boundary event; Q <= 0 when wrapping, Q held when saturating.
  - Q > Limit (Limit lowered mid-count): boundary event; Q <= 0 when wrapping, Q <= Limit when saturating.
- Down step:
  - Q > Limit: Q <= Limit, no event.
  - 0 < Q <= Limit: Q <= Q-1.
  - Q == 0: boundary event; Q <= Limit when wrapping, Q held at 0 when saturating.
- Limit == 0: Q stays 0 and every step is a boundary event.
- TerminalCount:
  - Asserted for exactly the one cycle after the edge that performed a boundary event; 0 otherwise.
  - Back-to-back boundary events (Limit == 0, or saturate held at the boundary) keep it high continuously.
- Overflow:
  - Set on any boundary event; stays set until ClearFlag, Load or Reset.
  - ClearFlag and a boundary event in the same cycle: set wins.
- Direction change (Up toggled between steps): allowed any cycle, no penalty. Latency from step to Q update is 1 clock.
- Arithmetic: all compares unsigned, SIZE bits. No carry-out beyond the boundary-event logic. Q never exceeds Limit after any step or load.
- Unknowns: Limit/Initial/Up/Saturate are sampled only on edges where they are used; no X is allowed to reach Q when Enable = 0 and Load = 0.

Optional Feature:
- Macro: MODULO_COUNTER_PRESCALER_EN.
- Defined:
  - Internal prescaler, width clog2(PRESCALE), counts Enable pulses.
  - A step occurs only on the Enable cycle where the prescaler == PRESCALE-1; the prescaler then returns to 0.
  - Non-Enable cycles freeze the prescaler.
  - Load and Reset zero it.
  - PRESCALE == 1 behaves as undefined.
- Undefined: no prescaler logic; every Enable cycle is a step.

Decomposition:
- Shared package, alongside the width macros:
  - Direction encodings DIR_UP/DIR_DOWN.
  - Mode encodings MODE_WRAP/MODE_SAT.
  - Default SIZE constant.
- One natural sub-module, modulo_counter_next: purely combinational.
  - Inputs: Q, Limit, Up, Saturate.
  - Outputs: next value and boundary-event bit.
- The top holds only registers and the prescaler.

Test Plan:
1. Reset with RESET_VALUE=5, SIZE=8 -> Q=5, TerminalCount=0, Overflow=0. Assert Reset mid-count at Q=3 -> Q=5 asynchronously, before the next edge.
2. Limit=3, Up=1, Saturate=0, Enable held 6 cycles from Q=0 -> Q sequence 1,2,3,0,1,2; TerminalCount high only the cycle Q shows 0; Overflow stays 1.
3. Limit=3, Up=0, Saturate=1 from Q=1, Enable 4 cycles -> Q 0,0,0,0; TerminalCount high for cycles 2-4; ClearFlag with no event -> Overflow=0.
4. Load=1, Initial=9, Limit=6, Enable=1 same cycle -> Q=6, Overflow cleared, no step. Then drop Limit to 2 and do an up step with Saturate=1 -> Q=2 with event.
5. Limit=0 -> every step leaves Q=0 and TerminalCount stays high; ClearFlag concurrent with an event -> Overflow remains 1.
6. With MODULO_COUNTER_PRESCALER_EN, PRESCALE=4, Limit=15, 12 Enable pulses interleaved with idle cycles -> Q goes 0,1,2,3, stepping on Enable pulses 4, 8 and 12. Load after 2 pulses restarts the 4-pulse window.
